// File: rtl/rx_uart_pkg.sv
// Shared types and helpers for the UART receiver: FSM state type and divisor clamping.
package rx_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  localparam logic [7:0] MIN_DIV = 8'd4;

  // Divisors below MIN_DIV leave no room for a mid-bit sample point.
  function automatic logic [7:0] clamp_div(input logic [7:0] d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

endpackage

// File: rtl/rx_uart_fifo.sv
// Byte FIFO for received data: extra pointer MSB distinguishes full from empty.
module rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic        pop_ok;
  logic        push_ok;

  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop_ok   = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = empty ? 8'h00 : mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/rx_uart.sv
// Memory-mapped 8N1 UART receiver with programmable clocks-per-bit, byte FIFO and sticky error flags.
module rx_uart
  import rx_uart_pkg::*;
#(
  parameter logic [7:0] DEFAULT_DIV = 8'd16,
  parameter int         DEPTH       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_line,
  input  logic [7:0] config_data,
  input  logic       config_enable,
  input  logic       read_enable,
  input  logic       clear_errors,
  output logic [7:0] read_data,
  output logic       rx_valid,
  output logic       overrun,
  output logic       framing_error
);

  logic       sync1_reg;
  logic       sync2_reg;
  logic       s;
  rx_state_e  state_reg;
  logic [7:0] div_reg;
  logic [7:0] cnt_reg;
  logic [2:0] bit_idx_reg;
  logic [7:0] shift_reg;
  logic       overrun_reg;
  logic       framing_reg;
  logic [7:0] half;
  logic       cnt_half;
  logic       cnt_full;
  logic       stop_sample;
  logic       push;
  logic       frame_err;
  logic       fifo_full;
  logic       fifo_empty;

  assign s        = sync2_reg;
  assign half     = {1'b0, div_reg[7:1]};
  assign cnt_half = (cnt_reg == half - 8'd1);
  assign cnt_full = (cnt_reg == div_reg - 8'd1);

  // A divisor write aborts the frame, so it also suppresses the stop-bit outcome.
  assign stop_sample = (state_reg == ST_STOP) && cnt_full && !config_enable;
  assign push        = stop_sample && s;
  assign frame_err   = stop_sample && !s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
    end else begin
      sync1_reg <= rx_line;
      sync2_reg <= sync1_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      div_reg     <= DEFAULT_DIV;
      cnt_reg     <= 8'd0;
      bit_idx_reg <= 3'd0;
      shift_reg   <= 8'd0;
    end else if (config_enable) begin
      div_reg     <= clamp_div(config_data);
      state_reg   <= ST_IDLE;
      cnt_reg     <= 8'd0;
      bit_idx_reg <= 3'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (!s) begin
            state_reg <= ST_START;
            cnt_reg   <= 8'd0;
          end
        end
        ST_START: begin
          if (cnt_half) begin
            cnt_reg     <= 8'd0;
            bit_idx_reg <= 3'd0;
            state_reg   <= s ? ST_IDLE : ST_DATA;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        ST_DATA: begin
          if (cnt_full) begin
            shift_reg[bit_idx_reg] <= s;
            cnt_reg                <= 8'd0;
            if (bit_idx_reg == 3'd7) begin
              state_reg <= ST_STOP;
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
            end
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        ST_STOP: begin
          if (cnt_full) begin
            cnt_reg   <= 8'd0;
            state_reg <= s ? ST_IDLE : ST_BREAK;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        ST_BREAK: begin
          // Hold here until the line recovers so a long break reports only once.
          if (s) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Set events take priority over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_reg <= 1'b0;
      framing_reg <= 1'b0;
    end else begin
      overrun_reg <= (push && fifo_full && !read_enable) || (overrun_reg && !clear_errors);
      framing_reg <= frame_err || (framing_reg && !clear_errors);
    end
  end

  rx_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(shift_reg),
    .pop      (read_enable),
    .pop_data (read_data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign rx_valid      = !fifo_empty;
  assign overrun       = overrun_reg;
  assign framing_error = framing_reg;

endmodule

// File: tb/tb_rx_uart.sv
// Bench for rx_uart: frame-level reference model (byte queue + scheduled stop-sample events) checked every cycle.
module tb_rx_uart;
  import rx_uart_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_line = 1'b1;
  logic [7:0] config_data = 8'h00;
  logic       config_enable = 1'b0;
  logic       read_enable = 1'b0;
  logic       clear_errors = 1'b0;
  logic [7:0] read_data;
  logic       rx_valid;
  logic       overrun;
  logic       framing_error;

  always #5 clk = ~clk;

  rx_uart #(
    .DEFAULT_DIV(8'd16),
    .DEPTH      (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_line      (rx_line),
    .config_data  (config_data),
    .config_enable(config_enable),
    .read_enable  (read_enable),
    .clear_errors (clear_errors),
    .read_data    (read_data),
    .rx_valid     (rx_valid),
    .overrun      (overrun),
    .framing_error(framing_error)
  );

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  // Reference state: FIFO contents, sticky flags, current bit time.
  logic [7:0] q[$];
  bit         m_ovr = 0;
  bit         m_fe = 0;
  int         m_div = 16;
  logic [7:0] push_evt[int];
  bit         fe_evt[int];

  bit rd_force = 0;
  bit rd_rand = 0;

  // Literal check requests handed to the compare process.
  int    req_id = 0;
  int    seen_id = 0;
  string req_name = "";
  int    req_sel = 0;
  int    req_exp = 0;

  // Model: advances on every edge; pushes/errors land on the edge the frame's stop bit is sampled.
  always @(posedge clk) begin
    bit pop;
    bit full_before;
    cyc = cyc + 1;
    if (rst) begin
      q.delete();
      m_ovr = 0;
      m_fe = 0;
    end else begin
      full_before = (q.size() == DEPTH);
      pop = read_enable && (q.size() > 0);
      if (clear_errors) begin
        m_ovr = 0;
        m_fe = 0;
      end
      if (pop) void'(q.pop_front());
      if (push_evt.exists(cyc)) begin
        if (!full_before || pop) q.push_back(push_evt[cyc]);
        else m_ovr = 1;
      end
      if (fe_evt.exists(cyc)) m_fe = 1;
    end
  end

  // Compare process: every cycle, plus any pending literal check.
  always @(negedge clk) begin
    logic       ev;
    logic [7:0] ed;
    logic       eo;
    logic       ef;
    int         got;
    ev = !rst && (q.size() > 0);
    ed = ev ? q[0] : 8'h00;
    eo = !rst && m_ovr;
    ef = !rst && m_fe;
    compared++;
    if ({rx_valid, read_data, overrun, framing_error} !== {ev, ed, eo, ef}) begin
      mismatched++;
      $display("FAIL cycle_%0d outputs: got valid=%b data=%02h ovr=%b fe=%b, required valid=%b data=%02h ovr=%b fe=%b",
               cyc, rx_valid, read_data, overrun, framing_error, ev, ed, eo, ef);
    end
    if (req_id != seen_id) begin
      seen_id = req_id;
      case (req_sel)
        0:       got = int'(rx_valid);
        1:       got = int'(read_data);
        2:       got = int'(overrun);
        3:       got = int'(framing_error);
        4:       got = int'(dut.div_reg);
        default: got = int'(dut.state_reg);
      endcase
      compared++;
      if (got != req_exp) begin
        mismatched++;
        $display("FAIL %s: got %0h required %0h", req_name, got, req_exp);
      end else begin
        $display("check %s ok (%0h)", req_name, got);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      read_enable = rd_force || (rd_rand && ($urandom_range(0, 3) == 0));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic lit(input string name, input int sel, input int exp);
    req_name = name;
    req_sel  = sel;
    req_exp  = exp;
    req_id++;
    tick();
  endtask

  task automatic read_pulse();
    rd_force = 1;
    tick();
    rd_force = 0;
    tick();
  endtask

  task automatic clear_pulse();
    clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0;
  endtask

  task automatic configure(input logic [7:0] cfg);
    config_data   = cfg;
    config_enable = 1'b1;
    tick();
    config_enable = 1'b0;
    m_div = (cfg < 8'd4) ? 4 : int'(cfg);
  endtask

  // Drives one frame; stop sample lands 3 (sync + detect) + half + 9 bit times after the start edge.
  task automatic send(input logic [7:0] b, input bit good, input int stop_low,
                      input int abort_after, input int abort_kind, input logic [7:0] cfg);
    int k, d, h, es, total, slot;
    k  = cyc;
    d  = m_div;
    h  = d / 2;
    es = k + 3 + h + 9 * d;
    total = good ? 10 * d : (9 + stop_low) * d;
    if (abort_after < 0) begin
      if (good) push_evt[es] = b;
      else      fe_evt[es] = 1;
    end
    $display("frame byte=%02h div=%0d good=%0d abort=%0d", b, d, good, abort_after);
    for (int t = 0; t < total; t++) begin
      if (t == abort_after) begin
        rx_line = 1'b1;
        if (abort_kind == 0) begin
          configure(cfg);
        end else begin
          rst = 1'b1;
          idle(2);
          rst = 1'b0;
          m_div = 16;
        end
        return;
      end
      slot = t / d;
      if (slot == 0)      rx_line = 1'b0;
      else if (slot <= 8) rx_line = b[slot-1];
      else                rx_line = good;
      tick();
    end
    rx_line = 1'b1;
  endtask

  initial begin
    idle(3);
    lit("reset_valid", 0, 0);
    lit("reset_data", 1, 0);
    lit("reset_ovr", 2, 0);
    lit("reset_fe", 3, 0);
    lit("reset_div", 4, 16);
    rst = 1'b0;
    tick();
    configure(8'd8);

    // Clean frame, then one pop.
    send(8'hA5, 1, 0, -1, 0, 8'h00);
    idle(3 * m_div);
    lit("a5_valid", 0, 1);
    lit("a5_data", 1, 8'hA5);
    read_pulse();
    lit("a5_pop_valid", 0, 0);
    lit("a5_pop_data", 1, 0);

    // Two-clock glitch must be rejected.
    rx_line = 1'b0;
    idle(2);
    rx_line = 1'b1;
    idle(3 * m_div);
    lit("glitch_state", 5, int'(ST_IDLE));
    lit("glitch_valid", 0, 0);
    lit("glitch_fe", 3, 0);

    // Stop bit held low for 20 bit times.
    send(8'h3C, 0, 20, -1, 0, 8'h00);
    idle(3 * m_div);
    lit("break_fe", 3, 1);
    lit("break_valid", 0, 0);
    send(8'h11, 1, 0, -1, 0, 8'h00);
    idle(3 * m_div);
    lit("after_break_data", 1, 8'h11);
    read_pulse();
    clear_pulse();
    lit("break_cleared", 3, 0);

    // Overrun: five bytes into four entries.
    for (int i = 1; i <= 5; i++) begin
      send(8'(i), 1, 0, -1, 0, 8'h00);
      idle(2 * m_div);
    end
    lit("ovr_set", 2, 1);
    for (int i = 1; i <= 4; i++) begin
      lit($sformatf("ovr_read_%0d", i), 1, i);
      read_pulse();
    end
    lit("ovr_drained", 0, 0);
    clear_pulse();
    lit("ovr_cleared", 2, 0);

    // Divisor write mid-frame aborts it and clamps to 4.
    send(8'h77, 1, 0, 4 * m_div + 3, 0, 8'h02);
    idle(4 * m_div);
    lit("cfg_div", 4, 4);
    lit("cfg_state", 5, int'(ST_IDLE));
    lit("cfg_valid", 0, 0);
    send(8'hC3, 1, 0, -1, 0, 8'h00);
    idle(3 * m_div);
    lit("div4_data", 1, 8'hC3);

    // Reset during data bits of 0xFF, with 0xC3 still queued.
    send(8'hFF, 1, 0, 5 * m_div, 1, 8'h00);
    lit("rst_valid", 0, 0);
    lit("rst_data", 1, 0);
    lit("rst_div", 4, 16);
    idle(2 * m_div);
    send(8'h5A, 1, 0, -1, 0, 8'h00);
    idle(3 * m_div);
    lit("after_rst_data", 1, 8'h5A);
    read_pulse();

    // Randomized traffic against the model.
    rd_rand = 1;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 5) == 0) configure(8'($urandom_range(0, 20)));
      if ($urandom_range(0, 9) == 0) begin
        rx_line = 1'b0;
        idle(2);
        rx_line = 1'b1;
        idle(2 * m_div);
      end
      if ($urandom_range(0, 7) == 0)
        send(8'($urandom_range(0, 255)), 0, $urandom_range(1, 3), -1, 0, 8'h00);
      else
        send(8'($urandom_range(0, 255)), 1, 0, -1, 0, 8'h00);
      idle(2 * m_div + $urandom_range(0, 5));
      if ($urandom_range(0, 5) == 0) clear_pulse();
    end
    rd_rand = 0;
    idle(4);
    while (rx_valid) read_pulse();
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
